hub75_fb_readout: RTL and testbench

- Counterpart of the frame-buffer write-in path: fetches one display row (all banks) from the shared frame buffer into an internal double-buffered line buffer.
- The scan/shift-out logic then reads pixels from that line buffer by column.
- Gains frame-buffer access through the same req/gnt/rel arbiter as the write-in path.
- Feeds the bit-plane/shifter stage of the HUB75 pipeline.

---
 rtl/hub75_fb_readout.sv | 167 ++++++++++++++++
 tb/tb_hub75_fb_readout.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hub75_fb_readout.sv
// HUB75 frame-buffer readout: fetches one display row (all banks) into a double-buffered line buffer.
// Optional macro HUB75_FB_READOUT_REGOUT_EN adds an output register on rd_data (2-cycle read latency).
module hub75_fb_readout #(
   parameter int N_BANKS     = 2,
   parameter int N_ROWS      = 32,
   parameter int N_COLS      = 64,
   parameter int BITDEPTH    = 24,
   parameter int FB_AW       = 13,
   parameter int FB_DW       = 16,
   parameter int FB_DC       = 2,
   parameter int LOG_N_BANKS = $clog2(N_BANKS),
   parameter int LOG_N_ROWS  = $clog2(N_ROWS),
   parameter int LOG_N_COLS  = $clog2(N_COLS)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [LOG_N_ROWS-1:0]       rd_row_addr,
   input  logic                        rd_row_load,
   output logic                        rd_row_rdy,
   input  logic                        rd_row_swap,
   input  logic [LOG_N_COLS-1:0]       rd_col_addr,
   input  logic                        rd_en,
   output logic [N_BANKS*BITDEPTH-1:0] rd_data,
   output logic                        ctrl_req,
   input  logic                        ctrl_gnt,
   output logic                        ctrl_rel,
   output logic [FB_AW-1:0]            fb_addr,
   output logic                        fb_rden,
   input  logic [FB_DW-1:0]            fb_data
);

   localparam int LOG_DC = (FB_DC > 1) ? $clog2(FB_DC) : 0;
   localparam int CW     = LOG_N_COLS + LOG_N_BANKS + LOG_DC;
   localparam logic [CW-1:0] CNT_LAST = CW'(N_COLS * N_BANKS * FB_DC - 1);

   logic                  pending_q, pending_d;
   logic                  running_q, running_d;
   logic                  rdy_q, rdy_d;
   logic                  front_q, front_d;
   logic                  tgt_q, tgt_d;
   logic [LOG_N_ROWS-1:0] row_q, row_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  fb_rden_q;
   logic [FB_AW-1:0]      fb_addr_q;
   logic                  rel_q;
   logic                  rsp_vld_q;
   logic [CW-1:0]         rsp_idx_q;

   always_comb begin
      pending_d = pending_q;
      running_d = running_q;
      rdy_d     = rdy_q;
      front_d   = front_q ^ rd_row_swap;
      tgt_d     = tgt_q;
      row_d     = row_q;
      cnt_d     = cnt_q;
      // Target is the back buffer as seen after any same-cycle swap.
      if (rd_row_load && rdy_q) begin
         pending_d = 1'b1;
         rdy_d     = 1'b0;
         row_d     = rd_row_addr;
         tgt_d     = ~front_d;
      end
      if (ctrl_gnt && pending_q) begin
         pending_d = 1'b0;
         running_d = 1'b1;
         cnt_d     = '0;
      end
      if (running_q) begin
         cnt_d = cnt_q + CW'(1);
         if (cnt_q == CNT_LAST) begin
            running_d = 1'b0;
            cnt_d     = '0;
         end
      end
      if (rel_q) rdy_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q <= 1'b0;
         running_q <= 1'b0;
         rdy_q     <= 1'b1;
         front_q   <= 1'b0;
         tgt_q     <= 1'b0;
         row_q     <= '0;
         cnt_q     <= '0;
         fb_rden_q <= 1'b0;
         fb_addr_q <= '0;
         rel_q     <= 1'b0;
         rsp_vld_q <= 1'b0;
         rsp_idx_q <= '0;
      end else begin
         pending_q <= pending_d;
         running_q <= running_d;
         rdy_q     <= rdy_d;
         front_q   <= front_d;
         tgt_q     <= tgt_d;
         row_q     <= row_d;
         cnt_q     <= cnt_d;
         fb_rden_q <= running_q;
         if (running_q) fb_addr_q <= {row_q, cnt_q};
         rel_q     <= fb_rden_q && (fb_addr_q[CW-1:0] == CNT_LAST);
         // fb_data for the read issued last cycle arrives alongside these.
         rsp_vld_q <= fb_rden_q;
         rsp_idx_q <= fb_addr_q[CW-1:0];
      end
   end

   logic [LOG_N_COLS-1:0]  wr_col;
   logic [LOG_N_BANKS-1:0] wr_bank;
   logic                   last_word;
   logic [BITDEPTH-1:0]    pix;

   assign wr_col  = rsp_idx_q[LOG_DC+LOG_N_BANKS +: LOG_N_COLS];
   assign wr_bank = rsp_idx_q[LOG_DC +: LOG_N_BANKS];

   if (FB_DC > 1) begin : g_dc
      logic [LOG_DC-1:0]              dc;
      logic [FB_DW*(FB_DC-1)-1:0]     acc_q;
      assign dc        = rsp_idx_q[LOG_DC-1:0];
      assign last_word = (dc == LOG_DC'(FB_DC - 1));
      always_ff @(posedge clk) begin
         if (rsp_vld_q && !last_word) acc_q[dc*FB_DW +: FB_DW] <= fb_data;
      end
      assign pix = BITDEPTH'({fb_data, acc_q});
   end else begin : g_nodc
      assign last_word = 1'b1;
      assign pix       = BITDEPTH'(fb_data);
   end

   logic [BITDEPTH-1:0] lb_mem [N_BANKS][2*N_COLS];

   always_ff @(posedge clk) begin
      if (rsp_vld_q && last_word) lb_mem[wr_bank][{tgt_q, wr_col}] <= pix;
   end

   logic [N_BANKS*BITDEPTH-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q <= '0;
      end else if (rd_en) begin
         for (int b = 0; b < N_BANKS; b++) begin
            rdata_q[b*BITDEPTH +: BITDEPTH] <= lb_mem[b][{front_q, rd_col_addr}];
         end
      end
   end

`ifdef HUB75_FB_READOUT_REGOUT_EN
   logic [N_BANKS*BITDEPTH-1:0] rdata_p_q;
   always_ff @(posedge clk) begin
      if (rst) rdata_p_q <= '0;
      else     rdata_p_q <= rdata_q;
   end
   assign rd_data = rdata_p_q;
`else
   assign rd_data = rdata_q;
`endif

   assign rd_row_rdy = rdy_q;
   assign ctrl_req   = pending_q;
   assign ctrl_rel   = rel_q;
   assign fb_addr    = fb_addr_q;
   assign fb_rden    = fb_rden_q;

endmodule

// File: tb/tb_hub75_fb_readout.sv
// Scoreboard bench for hub75_fb_readout: FB reads and line-buffer reads are checked against queued expectations.
`timescale 1ns/1ps
module tb_hub75_fb_readout;
`ifdef HUB75_FB_READOUT_REGOUT_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [4:0]  rd_row_addr = '0;
   logic        rd_row_load = 1'b0;
   logic        rd_row_rdy;
   logic        rd_row_swap = 1'b0;
   logic [5:0]  rd_col_addr = '0;
   logic        rd_en = 1'b0;
   logic [47:0] rd_data;
   logic        ctrl_req;
   logic        ctrl_gnt = 1'b0;
   logic        ctrl_rel;
   logic [12:0] fb_addr;
   logic        fb_rden;
   logic [15:0] fb_data = '0;

   hub75_fb_readout dut (
      .clk(clk), .rst(rst),
      .rd_row_addr(rd_row_addr), .rd_row_load(rd_row_load), .rd_row_rdy(rd_row_rdy),
      .rd_row_swap(rd_row_swap), .rd_col_addr(rd_col_addr), .rd_en(rd_en), .rd_data(rd_data),
      .ctrl_req(ctrl_req), .ctrl_gnt(ctrl_gnt), .ctrl_rel(ctrl_rel),
      .fb_addr(fb_addr), .fb_rden(fb_rden), .fb_data(fb_data)
   );

   always #5 clk = ~clk;

   // Frame buffer model: word = addr ^ 0x5A5A, one cycle after the read strobe.
   always @(posedge clk) if (fb_rden) fb_data <= 16'(fb_addr) ^ 16'h5A5A;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;
   logic [1:0] ren_sh = 2'b00;
   always @(posedge clk) ren_sh <= {ren_sh[0], rd_en};

   int checks = 0;
   int failures = 0;
   logic [12:0] addr_q [$];
   logic [47:0] rdq [$];
   int rden_tot = 0, rel_tot = 0, run_start = 0, last_rden = 0, rel_cyc = 0, rise_cyc = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   function automatic logic [23:0] exp_pix(input int r, input int c, input int b);
      logic [15:0] lo, hi;
      lo = 16'((r << 8) | (c << 2) | (b << 1)) ^ 16'h5A5A;
      hi = 16'((r << 8) | (c << 2) | (b << 1) | 1) ^ 16'h5A5A;
      return {hi[7:0], lo};
   endfunction

   function automatic logic [47:0] exp_row(input int r, input int c);
      return {exp_pix(r, c, 1), exp_pix(r, c, 0)};
   endfunction

   // Monitor: pops expectations whenever the DUT presents an FB read or read data.
   initial begin
      logic prev_rden, rdy_prev;
      prev_rden = 1'b0;
      rdy_prev  = 1'b1;
      forever begin
         @(negedge clk);
         if (fb_rden) begin
            if (!prev_rden) run_start = cyc;
            last_rden = cyc;
            rden_tot++;
            if (addr_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL fb_extra actual=read@%0h required=no_read", fb_addr);
            end else begin
               chk("fb_addr", 64'(fb_addr), 64'(addr_q.pop_front()));
            end
         end
         prev_rden = fb_rden;
         if (ctrl_rel) begin
            rel_tot++;
            rel_cyc = cyc;
         end
         if (rd_row_rdy && !rdy_prev) rise_cyc = cyc;
         rdy_prev = rd_row_rdy;
         if (ren_sh[LAT-1]) begin
            if (rdq.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL rd_extra actual=%0h required=none", rd_data);
            end else begin
               chk("rd_data", 64'(rd_data), 64'(rdq.pop_front()));
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_rdy(input string nm, output logic saw_req);
      saw_req = 1'b0;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         if (ctrl_req) saw_req = 1'b1;
         if (rd_row_rdy) return;
      end
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=rdy_low required=rdy_high", nm);
   endtask

   task automatic load_row(input int r, input int n_exp);
      for (int i = 0; i < n_exp; i++) addr_q.push_back(13'((r << 8) | i));
      step();
      rd_row_addr = 5'(r);
      rd_row_load = 1'b1;
      step();
      rd_row_load = 1'b0;
   endtask

   task automatic rd_col(input int r, input int c);
      rd_en = 1'b1;
      rd_col_addr = 6'(c);
      rdq.push_back(exp_row(r, c));
      step();
      rd_en = 1'b0;
   endtask

   task automatic swap();
      rd_row_swap = 1'b1;
      step();
      rd_row_swap = 1'b0;
   endtask

   initial begin
      int b_rden, b_rel, n;
      logic saw;
      repeat (3) step();
      @(negedge clk);
      chk("rst_state", {rd_row_rdy, ctrl_req, ctrl_rel, fb_rden}, 4'b1000);
      chk("rst_fb_addr", 64'(fb_addr), 64'h0);
      chk("rst_rd_data", 64'(rd_data), 64'h0);
      step();
      rst = 1'b0;

      // Idle after reset
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("idle", {rd_row_rdy, ctrl_req, fb_rden, ctrl_rel}, 4'b1000);
      end
      chk("idle_rel", 64'(rel_tot), 64'h0);

      // Load row 5 with grant 3 cycles after the load pulse
      b_rden = rden_tot;
      b_rel  = rel_tot;
      load_row(5, 256);
      @(negedge clk);
      chk("load_rdy", 64'(rd_row_rdy), 64'h0);
      chk("load_req", 64'(ctrl_req), 64'h1);
      step();
      @(negedge clk);
      chk("req_hold", 64'(ctrl_req), 64'h1);
      step();
      ctrl_gnt = 1'b1;
      @(negedge clk);
      chk("req_at_gnt", 64'(ctrl_req), 64'h1);
      step();
      ctrl_gnt = 1'b0;
      wait_rdy("row5", saw);
      chk("req_after_gnt", 64'(saw), 64'h0);
      step();
      @(negedge clk);
      chk("rden_count", 64'(rden_tot - b_rden), 64'd256);
      chk("rden_consec", 64'(last_rden - run_start), 64'd255);
      chk("rel_count", 64'(rel_tot - b_rel), 64'd1);
      chk("rel_timing", 64'(rel_cyc - last_rden), 64'd1);
      chk("rdy_timing", 64'(rise_cyc - last_rden), 64'd2);
      chk("fb_q_drained", 64'(addr_q.size()), 64'd0);

      // Swap and read row 5 back
      step();
      swap();
      rd_col(5, 0);
      rd_col(5, 31);
      rd_col(5, 63);
      repeat (3) step();
      @(negedge clk);
      chk("rd_hold", 64'(rd_data), 64'(exp_row(5, 63)));

      // Load row 7; a second load for row 9 while busy must be ignored
      b_rden = rden_tot;
      b_rel  = rel_tot;
      load_row(7, 256);
      rd_row_addr = 5'd9;
      rd_row_load = 1'b1;
      step();
      rd_row_load = 1'b0;
      rd_row_addr = 5'd0;
      ctrl_gnt = 1'b1;
      step();
      ctrl_gnt = 1'b0;
      wait_rdy("row7", saw);
      chk("no_rereq", 64'(saw), 64'h0);
      step();
      @(negedge clk);
      chk("row7_rden_count", 64'(rden_tot - b_rden), 64'd256);
      chk("row7_rel_count", 64'(rel_tot - b_rel), 64'd1);
      chk("row7_req_idle", 64'(ctrl_req), 64'h0);
      step();
      swap();
      rd_col(7, 1);
      rd_col(7, 40);
      swap();
      rd_col(5, 31);
      repeat (3) step();

      // Reset in the middle of a fetch
      b_rden = rden_tot;
      b_rel  = rel_tot;
      load_row(3, 100);
      step();
      ctrl_gnt = 1'b1;
      step();
      ctrl_gnt = 1'b0;
      n = 0;
      for (int i = 0; i < 400 && n < 100; i++) begin
         @(negedge clk);
         if (fb_rden) n++;
      end
      chk("mid_rden_reached", 64'(n), 64'd100);
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_state", {fb_rden, ctrl_req, rd_row_rdy}, 3'b001);
      repeat (6) step();
      @(negedge clk);
      chk("mid_rst_no_rel", 64'(rel_tot - b_rel), 64'd0);
      chk("mid_rst_rden", 64'(rden_tot - b_rden), 64'd100);
      chk("mid_rst_fb_q", 64'(addr_q.size()), 64'd0);

      repeat (3) step();
      chk("rd_q_drained", 64'(rdq.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      failures++;
      $display("FAIL watchdog actual=running required=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

endmodule
